// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default geometry, word widths and the
// state encodings used by the input frame loader.
package ldpc_pkg;

  localparam int LDPC_DATA_W = 8;   // decoder LLR width (two's complement)
  localparam int LDPC_IN_W   = 10;  // channel LLR width (two's complement)
  localparam int LDPC_R      = 5;   // block rows
  localparam int LDPC_D      = 8;   // circulant size
  localparam int LDPC_C      = 10;  // block columns of the base matrix
  localparam int LDPC_N      = LDPC_R * LDPC_D;  // LLRs per frame

  // Occupancy of one ping-pong frame bank.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Write-side FSM: FILL packs beats, DROP discards the tail of an overlong frame.
  typedef enum logic {
    WR_FILL = 1'b0,
    WR_DROP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/llr_sat.sv
// Symmetric saturator: narrows a signed in_w LLR to data_w bits, clipping to
// +/-(2^(data_w-1)-1) so the most negative code is never produced.
module llr_sat
  import ldpc_pkg::*;
#(
  parameter int in_w   = LDPC_IN_W,
  parameter int data_w = LDPC_DATA_W
) (
  input  logic signed [in_w-1:0]   llr_i,
  output logic signed [data_w-1:0] llr_o
);

  localparam int MAG = (2 ** (data_w - 1)) - 1;

  localparam logic signed [in_w-1:0]   HI_IN  = in_w'(MAG);
  localparam logic signed [in_w-1:0]   LO_IN  = in_w'(-MAG);
  localparam logic signed [data_w-1:0] HI_OUT = data_w'(MAG);
  localparam logic signed [data_w-1:0] LO_OUT = data_w'(-MAG);

  // Clip out-of-range values, otherwise keep the low data_w bits.
  always_comb begin
    if (llr_i > HI_IN) begin
      llr_o = HI_OUT;
    end else if (llr_i < LO_IN) begin
      llr_o = LO_OUT;
    end else begin
      llr_o = llr_i[data_w-1:0];
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// LDPC input stage: saturates channel LLRs and packs them into a ping-pong pair
// of frame banks; a complete frame is held on l_bus until the decoder acks it.
module llr_frame_loader
  import ldpc_pkg::*;
#(
  parameter int data_w = LDPC_DATA_W,
  parameter int in_w   = LDPC_IN_W,
  parameter int R      = LDPC_R,
  parameter int D      = LDPC_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [in_w-1:0]         in_llr,
  input  logic                    in_last,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic [data_w*R*D-1:0]   l_bus,
  output logic                    err_len
);

  localparam int N  = R * D;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  wr_state_e         wstate_q, wstate_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  bank_state_e       bstate_q [2];
  bank_state_e       bstate_d [2];
  logic [data_w-1:0] bank_q [2][N];
  logic [data_w-1:0] bank_d [2][N];
  logic              err_len_q, err_len_d;

  logic [data_w-1:0] sat_llr;
  logic              xfer;
  logic              ack;

  llr_sat #(
    .in_w   (in_w),
    .data_w (data_w)
  ) u_sat (
    .llr_i (in_llr),
    .llr_o (sat_llr)
  );

  // A full write bank stalls the stream; DROP always accepts so overlong tails drain.
  assign in_ready    = !rst && ((wstate_q == WR_DROP) || (bstate_q[wr_sel_q] == BANK_EMPTY));
  assign xfer        = in_valid && in_ready;
  assign frame_valid = (bstate_q[rd_sel_q] == BANK_FULL);
  assign ack         = frame_ack && frame_valid;
  assign err_len     = err_len_q;

  // Next-state logic: read-side release and write-side packing act on different banks.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    bstate_d  = bstate_q;
    bank_d    = bank_q;
    err_len_d = 1'b0;

    if (ack) begin
      bstate_d[rd_sel_q] = BANK_EMPTY;
      rd_sel_d           = ~rd_sel_q;
    end

    if (xfer) begin
      unique case (wstate_q)
        WR_FILL: begin
          bank_d[wr_sel_q][wcnt_q] = sat_llr;
          if (in_last) begin
            wcnt_d = '0;
            if (wcnt_q == LAST_IDX) begin
              bstate_d[wr_sel_q] = BANK_FULL;
              wr_sel_d           = ~wr_sel_q;
            end else begin
              err_len_d = 1'b1;  // short frame: discarded, bank stays EMPTY
            end
          end else if (wcnt_q == LAST_IDX) begin
            err_len_d = 1'b1;    // long frame: discard until its in_last
            wcnt_d    = '0;
            wstate_d  = WR_DROP;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        WR_DROP: begin
          if (in_last) begin
            wstate_d = WR_FILL;
          end
        end
        default: wstate_d = WR_FILL;
      endcase
    end
  end

  // State and bank registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= WR_FILL;
      wcnt_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      err_len_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bstate_q[b] <= BANK_EMPTY;
        // NOTE: the banks are cleared on reset because l_bus must read zero out of reset, not stale data.
        for (int n = 0; n < N; n++) begin
          bank_q[b][n] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      err_len_q <= err_len_d;
      bstate_q  <= bstate_d;
      bank_q    <= bank_d;
    end
  end

  // 2:1 bank mux flattened onto the wide VNU bus; LLR n lands in slice n.
  always_comb begin
    l_bus = '0;
    for (int n = 0; n < N; n++) begin
      l_bus[n*data_w +: data_w] = bank_q[rd_sel_q][n];
    end
  end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader: random LLR streams compared with a
// frame-level reference model (queue of completed frames plus a partial frame).
module tb_llr_frame_loader;

  localparam int DW  = 8;
  localparam int IW  = 10;
  localparam int NN  = 40;
  localparam int MAG = (1 << (DW - 1)) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              frame_ack = 1'b0;
  logic [IW-1:0]     in_llr = '0;
  logic              in_ready;
  logic              frame_valid;
  logic              err_len;
  logic [DW*NN-1:0]  l_bus;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW*NN-1:0] frames[$];  // completed frames in delivery order
  logic [DW-1:0]    cur[$];     // saturated LLRs of the frame in progress
  bit               dropping;
  bit               exp_err;

  llr_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_llr      (in_llr),
    .in_last     (in_last),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .l_bus       (l_bus),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sat(input int v);
    int r;
    r = (v > MAG) ? MAG : ((v < -MAG) ? -MAG : v);
    return DW'(r);
  endfunction

  // Two banks: the loader can take data unless two frames are already waiting.
  function automatic bit m_ready();
    return dropping || (frames.size() < 2);
  endfunction

  function automatic int rnd_llr();
    return int'($urandom_range(1023)) - 512;
  endfunction

  task automatic m_reset();
    frames.delete();
    cur.delete();
    dropping = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Drive one clock cycle and advance the model; outputs are then sampled 1ns after the edge.
  task automatic cycle(input bit v, input int llr, input bit last, input bit ack);
    bit xfer;
    bit acked;
    logic [DW*NN-1:0] f;
    in_valid  = v;
    in_llr    = IW'(llr);
    in_last   = last;
    frame_ack = ack;
    xfer  = v && m_ready();
    acked = ack && (frames.size() > 0);
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (acked) void'(frames.pop_front());
    if (xfer) begin
      if (dropping) begin
        if (last) dropping = 1'b0;
      end else begin
        cur.push_back(sat(llr));
        if (last) begin
          if (cur.size() == NN) begin
            f = '0;
            for (int i = 0; i < NN; i++) f[i*DW +: DW] = cur[i];
            frames.push_back(f);
          end else begin
            exp_err = 1'b1;
          end
          cur.delete();
        end else if (cur.size() == NN) begin
          exp_err = 1'b1;
          cur.delete();
          dropping = 1'b1;
        end
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
  endtask

  // Plain stimulus: a random frame of len beats with in_last on the final beat.
  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) cycle(1'b1, rnd_llr(), i == len - 1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b want=0", frame_valid); end
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err_len got=%b want=0", err_len); end
    total++; if (l_bus !== '0) begin bad++; $display("FAIL reset_l_bus got=%h want=0", l_bus); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_ramp();
    logic [DW*NN-1:0] exp_bus;
    for (int n = 0; n < NN; n++) begin
      exp_bus[n*DW +: DW] = DW'(n);
      cycle(1'b1, n, n == NN - 1, 1'b0);
      total++; if (frame_valid !== (n == NN - 1)) begin bad++; $display("FAIL ramp_frame_valid beat=%0d got=%b want=%b", n, frame_valid, n == NN - 1); end
    end
    total++; if (l_bus !== exp_bus) begin bad++; $display("FAIL ramp_l_bus got=%h want=%h", l_bus, exp_bus); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 0, 1'b0, 1'b0);
      total++; if (l_bus !== exp_bus || frame_valid !== 1'b1) begin bad++; $display("FAIL ramp_hold cyc=%0d valid=%b bus=%h want=%h", k, frame_valid, l_bus, exp_bus); end
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL ramp_ack_release got=%b want=0", frame_valid); end
  endtask

  task automatic test_saturation();
    int vals[4] = '{300, -300, 127, -128};
    for (int i = 0; i < NN; i++) cycle(1'b1, (i < 4) ? vals[i] : rnd_llr(), i == NN - 1, 1'b0);
    total++; if (l_bus[7:0] !== 8'h7f) begin bad++; $display("FAIL sat_pos_300 got=%h want=7f", l_bus[7:0]); end
    total++; if (l_bus[15:8] !== 8'h81) begin bad++; $display("FAIL sat_neg_300 got=%h want=81", l_bus[15:8]); end
    total++; if (l_bus[23:16] !== 8'h7f) begin bad++; $display("FAIL sat_pos_127 got=%h want=7f", l_bus[23:16]); end
    total++; if (l_bus[31:24] !== 8'h81) begin bad++; $display("FAIL sat_neg_128 got=%h want=81", l_bus[31:24]); end
    total++; if (frames.size() != 1 || l_bus !== frames[0]) begin bad++; $display("FAIL sat_frame got=%h want=%h", l_bus, (frames.size() > 0) ? frames[0] : '0); end
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [DW*NN-1:0] second;
    for (int i = 0; i < 2 * NN; i++) begin
      cycle(1'b1, rnd_llr(), (i % NN) == NN - 1, 1'b0);
      total++; if (in_ready !== m_ready() || frame_valid !== (frames.size() > 0)) begin bad++; $display("FAIL b2b_flags beat=%0d ready=%b/%b valid=%b/%b", i, in_ready, m_ready(), frame_valid, frames.size() > 0); end
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", in_ready); end
    total++; if (frames.size() != 2 || l_bus !== frames[0]) begin bad++; $display("FAIL b2b_first got=%h want=%h", l_bus, (frames.size() > 0) ? frames[0] : '0); end
    second = (frames.size() > 1) ? frames[1] : '0;
    cycle(1'b0, 0, 1'b0, 1'b1);
    total++; if (frame_valid !== 1'b1 || l_bus !== second) begin bad++; $display("FAIL b2b_handoff valid=%b got=%h want=%h", frame_valid, l_bus, second); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_rise got=%b want=1", in_ready); end
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stream();
    int sent = 0;
    int cyc  = 0;
    bit v;
    while (sent < 3 * NN && cyc < 2000) begin
      v = ($urandom_range(9) < 8);
      if (v && m_ready()) begin
        cycle(1'b1, rnd_llr(), (sent % NN) == NN - 1, $urandom_range(1) == 1);
        sent++;
      end else begin
        cycle(v, rnd_llr(), 1'b0, $urandom_range(1) == 1);
      end
      cyc++;
      total++; if (in_ready !== m_ready() || frame_valid !== (frames.size() > 0)) begin bad++; $display("FAIL stream_flags cyc=%0d ready=%b/%b valid=%b/%b", cyc, in_ready, m_ready(), frame_valid, frames.size() > 0); end
      if (frames.size() > 0) begin
        total++; if (l_bus !== frames[0]) begin bad++; $display("FAIL stream_l_bus cyc=%0d got=%h want=%h", cyc, l_bus, frames[0]); end
      end
    end
    total++; if (sent != 3 * NN) begin bad++; $display("FAIL stream_timeout sent=%0d want=%0d", sent, 3 * NN); end
    repeat (2) cycle(1'b0, 0, 1'b0, 1'b1);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", frame_valid); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_llr(), i == 9, 1'b0);
    total++; if (err_len !== 1'b1) begin bad++; $display("FAIL short_err_pulse got=%b want=1", err_len); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL short_no_frame got=%b want=0", frame_valid); end
    cycle(1'b0, 0, 1'b0, 1'b0);
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL short_err_one_cycle got=%b want=0", err_len); end
    send_frame(NN);
    total++; if (frame_valid !== 1'b1 || frames.size() != 1 || l_bus !== frames[0]) begin bad++; $display("FAIL short_next_frame valid=%b got=%h", frame_valid, l_bus); end
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < 45; i++) begin
      cycle(1'b1, rnd_llr(), i == 44, 1'b0);
      total++; if (err_len !== (i == NN - 1)) begin bad++; $display("FAIL long_err beat=%0d got=%b want=%b", i + 1, err_len, i == NN - 1); end
      total++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL long_flags beat=%0d valid=%b ready=%b want 0/1", i + 1, frame_valid, in_ready); end
    end
    send_frame(NN);
    total++; if (frame_valid !== 1'b1 || frames.size() != 1 || l_bus !== frames[0]) begin bad++; $display("FAIL long_next_frame valid=%b got=%h", frame_valid, l_bus); end
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    send_frame(NN);
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd_llr(), 1'b0, 1'b0);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL midrst_held got=%b want=1", frame_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    total++; if (frame_valid !== 1'b0 || l_bus !== '0) begin bad++; $display("FAIL midrst_clear valid=%b bus=%h want 0/0", frame_valid, l_bus); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    send_frame(NN);
    total++; if (frame_valid !== 1'b1 || frames.size() != 1 || l_bus !== frames[0]) begin bad++; $display("FAIL midrst_fresh valid=%b got=%h", frame_valid, l_bus); end
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    m_reset();
    test_reset();
    test_ramp();
    test_saturation();
    test_back_to_back();
    test_stream();
    test_short_frame();
    test_long_frame();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llr_frame_loader.md
# llr_frame_loader

Upstream input stage of the LDPC decoder. Accepts channel LLRs one per beat over a valid/ready stream, saturates each to the decoder word width, and packs them into a ping-pong pair of frame buffers. A completed frame is presented as one wide bus, `l_bus`, to the variable-node array's `l` inputs, and is held until the decoder acknowledges it. The second bank fills meanwhile, so back-to-back frames stream without stalls.

## Interface
- `data_w`, default 8: decoder LLR width (two's complement).
- `in_w`, default 10: channel LLR width (two's complement), must be ≥ `data_w`.
- `R`, default 5: block rows.
- `D`, default 8: circulant size.
- Derived `N` = `R*D` (40): LLRs per frame.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: loader can accept a beat.
- `in_llr` in `in_w`: channel LLR.
- `in_last` in 1: marks the final beat of a frame.
- `frame_valid` out 1: `l_bus` holds a complete frame.
- `frame_ack` in 1: decoder consumes the frame. Ignored unless `frame_valid` is high.
- `l_bus` out `data_w*N`: LLR n occupies `l_bus[n*data_w +: data_w]`, where n is arrival order. VNU i reads slice i.
- `err_len` out 1: one-cycle pulse when a frame has the wrong length.

## Operation
- Two banks, 0 and 1. Each bank is EMPTY or FULL.
- `wr_sel` selects the bank being filled. `rd_sel` selects the bank driven onto `l_bus`.
- Saturation: if `in_llr` > 2^(data_w-1)-1, store +127. If `in_llr` < -2^(data_w-1)+1, store -127 (symmetric; -128 is never produced). Otherwise store the value truncated to `data_w`.
- A beat transfers when `in_valid && in_ready`.
- Write FSM states:
  - IDLE/FILL, with counter `wcnt` 0..N-1:
    - Each transfer writes `bank[wr_sel][wcnt]` and increments `wcnt`.
    - Transfer with `in_last` at `wcnt==N-1`: bank becomes FULL, `wr_sel` toggles, `wcnt`←0.
    - Transfer with `in_last` at `wcnt<N-1`: `err_len` pulses, `wcnt`←0, bank stays EMPTY (frame discarded).
    - Transfer at `wcnt==N-1` without `in_last`: `err_len` pulses, `wcnt`←0, go to DROP.
  - DROP: accept and discard beats. A transfer with `in_last` returns to FILL.
- `in_ready` = (state==DROP) or (`bank[wr_sel]` EMPTY). It is 0 while `rst` is high.
- Read side:
  - `frame_valid` = `bank[rd_sel]` FULL.
  - On `frame_ack && frame_valid`: bank[`rd_sel`]←EMPTY and `rd_sel` toggles.
  - `l_bus` always reflects `bank[rd_sel]`. Its contents are stable while `frame_valid` is high.
- Simultaneous events:
  - Write completion into one bank and ack of the other in the same cycle: both take effect.
  - With both banks FULL, `in_ready` is 0 until an ack. The ack frees `bank[wr_sel]`, so `in_ready` rises the next cycle.
- Reset:
  - Outputs: `in_ready`=0 (1 from the first cycle after reset), `frame_valid`=0, `err_len`=0, `l_bus`=0.
  - Both banks are EMPTY and zeroed. `wr_sel`=`rd_sel`=0, `wcnt`=0, FSM in FILL.
  - Reset mid-frame discards partial and held frames.

## Timing
- Last beat accepted at cycle t → `frame_valid` high at t+1 (when its bank is `rd_sel`).
- Ack at cycle t → next bank's `frame_valid`/`l_bus` visible at t+1. A queued FULL bank therefore gives a one-cycle gap-free handoff.
- `err_len` is registered: it is high in the cycle after the offending transfer.
- Sustained throughput is 1 LLR/cycle provided the decoder acks within N cycles.
- `l_bus` is driven from registers via a 2:1 bank mux. There is no combinational path from `in_*` to any output.

## Structure
- Shared package `ldpc_pkg` holds:
  - Default `data_w`/`R`/`D`/`C`.
  - Derived `N`.
  - The bank-state enum (EMPTY/FULL).
  - The write-FSM enum (FILL/DROP).
- Sub-module `llr_sat`: combinational `in_w`→`data_w` symmetric saturator. It is reusable by the VNU for its internal sums.

## Test plan
1. Reset, then 40 beats of `in_llr`=n (n=0..39) with `in_last` on beat 40. Expect `frame_valid` the next cycle and `l_bus[n*8+:8]`==n. Hold `frame_ack` low: `l_bus` stays stable.
2. `in_llr`=300, -300, 127, -128 → stored 127, -127, 127, -127.
3. Stream two frames back-to-back with no ack. Expect `in_ready` to drop after beat 80. Ack once → second frame appears the next cycle and `in_ready` rises.
4. `in_last` on beat 10 → one `err_len` pulse, no `frame_valid`. The following correct 40-beat frame loads normally.
5. 45 beats with `in_last` on 45 → `err_len` at beat 40. Beats 41–45 are dropped; the next frame loads correctly.
6. Assert `rst` at beat 20 of a frame while a full frame is held → `frame_valid`=0 and `l_bus`=0 next cycle. A fresh frame after reset loads correctly.
